// File: rtl/cache_fetch_arbiter_if.sv
// ============================================================================
// cache_fetch_arbiter_if : requester/fetcher bundle for cache_fetch_arbiter, rev 1.0
// ============================================================================
`default_nettype none

interface cache_fetch_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_WAYS   = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*NUM_WAYS-1:0] req_way;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [NUM_REQ-1:0]          rsp_ready;
  logic [DATA_WIDTH-1:0]       rsp_data;
  logic                        rsp_err;
  logic [NUM_WAYS-1:0]         fetch_target_way;
  logic [DATA_WIDTH-1:0]       fetch_data_out;

  modport slave (
    input  req_valid, req_way, rsp_ready, fetch_data_out,
    output req_ready, rsp_valid, rsp_data, rsp_err, fetch_target_way
  );

  modport master (
    output req_valid, req_way, rsp_ready, fetch_data_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err, fetch_target_way
  );
endinterface

`default_nettype wire

// File: rtl/cache_fetch_arbiter.sv
// ============================================================================
// cache_fetch_arbiter : round-robin sharing of one cache data fetch port, rev 1.0
// ============================================================================
`default_nettype none

module cache_fetch_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_WAYS   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_fetch_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [NUM_WAYS-1:0]   way_q, way_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_WAYS-1:0]   pick_way;
  logic [NUM_WAYS-1:0]   way_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack_way
    assign way_arr[gi] = bus.req_way[gi*NUM_WAYS +: NUM_WAYS];
  end

  // First valid requester at or after the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    int         cand;
    logic [IDX_W-1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(ptr_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && bus.req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
    pick_way = way_arr[pick_idx];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    way_d   = way_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          way_d   = pick_way;
          if ($onehot(pick_way)) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
            data_d  = '0;
          end
        end
      end
      S_FETCH: begin
        data_d  = bus.fetch_data_out;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready[grant_q]) begin
          state_d = S_IDLE;
          ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      way_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      way_q   <= way_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = (state_q == S_IDLE) && pick_found && (pick_idx == IDX_W'(i));
      bus.rsp_valid[i] = (state_q == S_RESP) && (grant_q == IDX_W'(i));
    end
  end

  assign bus.fetch_target_way = (state_q == S_FETCH) ? way_q : '0;
  assign bus.rsp_data         = data_q;
  assign bus.rsp_err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_fetch_arbiter.sv
// ============================================================================
// tb_cache_fetch_arbiter : directed + random transaction checks, rev 1.0
// ============================================================================
`default_nettype none

module tb_cache_fetch_arbiter;
  localparam int NR = 4;
  localparam int NW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fetch_arbiter_if #(.NUM_REQ(NR), .NUM_WAYS(NW), .DATA_WIDTH(DW)) bus ();

  cache_fetch_arbiter #(.NUM_REQ(NR), .NUM_WAYS(NW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Fetcher: per-way data table, combinational on the way select.
  logic [DW-1:0] tbl [NW];
  logic [DW-1:0] fd;
  always_comb begin
    fd = '0;
    for (int i = 0; i < NW; i++) if (bus.fetch_target_way[i]) fd = fd | tbl[i];
  end
  assign bus.fetch_data_out = fd;

  int n_total = 0;
  int n_bad   = 0;
  int m_ptr   = 0;
  logic [DW-1:0] m_last_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] m, input int p);
    for (int k = 0; k < NR; k++) begin
      if (m[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic int way_index(input logic [NW-1:0] w);
    if ($countones(w) != 1) return -1;
    for (int i = 0; i < NW; i++) if (w[i]) return i;
    return -1;
  endfunction

  // Entered and left at posedge+1 with the DUT expected idle.
  task automatic run_txn(input logic [NR-1:0] vm, input logic [NR*NW-1:0] ways,
                         input int bp, output int g);
    logic [NR-1:0] rr;
    logic [NW-1:0] w;
    logic [DW-1:0] ed;
    logic          ee;
    int            wi;
    bus.req_valid = vm;
    bus.req_way   = ways;
    bus.rsp_ready = NR'($urandom);
    @(negedge clk);
    g = rr_pick(vm, m_ptr);
    chk("fetch_idle", 64'(bus.fetch_target_way), 64'(0));
    chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'(0));
    if (g < 0) begin
      chk("req_ready_none", 64'(bus.req_ready), 64'(0));
      chk("data_hold", 64'(bus.rsp_data), 64'(m_last_data));
      @(posedge clk); #1;
      return;
    end
    chk("req_ready", 64'(bus.req_ready), 64'(1) << g);
    w  = ways[g*NW +: NW];
    wi = way_index(w);
    ed = (wi >= 0) ? tbl[wi] : '0;
    ee = (wi < 0);
    @(posedge clk); #1;
    vm[g] = 1'b0;
    bus.req_valid = vm;
    bus.rsp_ready = NR'($urandom);
    if (wi >= 0) begin
      @(negedge clk);
      chk("fetch_way", 64'(bus.fetch_target_way), 64'(w));
      chk("req_ready_fetch", 64'(bus.req_ready), 64'(0));
      chk("rsp_valid_fetch", 64'(bus.rsp_valid), 64'(0));
      @(posedge clk); #1;
    end
    for (int c = 0; c <= bp; c++) begin
      rr = NR'($urandom);
      rr[g] = (c == bp);
      bus.rsp_ready = rr;
      @(negedge clk);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(1) << g);
      chk("rsp_data", 64'(bus.rsp_data), 64'(ed));
      chk("rsp_err", 64'(bus.rsp_err), 64'(ee));
      chk("req_ready_resp", 64'(bus.req_ready), 64'(0));
      chk("fetch_resp", 64'(bus.fetch_target_way), 64'(0));
      @(posedge clk); #1;
    end
    bus.rsp_ready = '0;
    m_ptr = (g + 1) % NR;
    m_last_data = ed;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_way   = '0;
    bus.rsp_ready = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_fetch", 64'(bus.fetch_target_way), 64'(0));
    chk("rst_data", 64'(bus.rsp_data), 64'(0));
    chk("rst_err", 64'(bus.rsp_err), 64'(0));
    m_ptr = 0;
    m_last_data = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    logic [NR-1:0]    pend;
    logic [NR*NW-1:0] pw;
    for (int i = 0; i < NW; i++) tbl[i] = $urandom;
    bus.req_valid = '0;
    bus.req_way   = '0;
    bus.rsp_ready = '0;
    do_reset();

    // Reset while requester 1 is being answered.
    bus.req_valid = 4'b0010;
    bus.req_way   = 16'h0010;
    @(negedge clk);
    chk("mid_grant", 64'(bus.req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0010));
    do_reset();
    run_txn(4'b0011, 16'h0021, 0, g);

    // Single request, data DEAD_BEEF on way 2.
    do_reset();
    tbl[2] = 32'hDEAD_BEEF;
    run_txn(4'b0100, 16'h0400, 0, g);
    run_txn(4'b0100, 16'h0400, 0, g);
    run_txn(4'b0000, 16'h0000, 0, g);

    // All requesters valid: rotating grants.
    do_reset();
    repeat (6) run_txn(4'b1111, 16'h1248, 0, g);

    // Backpressure on requester 0, requester 1 pending.
    do_reset();
    run_txn(4'b0011, 16'h0084, 10, g);
    run_txn(4'b0011, 16'h0084, 0, g);

    // Malformed ways from requester 3.
    do_reset();
    run_txn(4'b1000, 16'h0000, 1, g);
    run_txn(4'b1000, 16'h6000, 0, g);
    run_txn(4'b0000, 16'h0000, 0, g);

    // Wrap and skip around pointer 3.
    do_reset();
    run_txn(4'b0100, 16'h0100, 0, g);
    run_txn(4'b1010, 16'h8020, 0, g);
    run_txn(4'b0011, 16'h0021, 0, g);
    run_txn(4'b0010, 16'h0040, 0, g);

    // Random traffic with held pending requests and occasional drops.
    pend = '0;
    pw   = '0;
    repeat (250) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          if ($urandom_range(0, 7) == 0) pw[i*NW +: NW] = NW'($urandom);
          else pw[i*NW +: NW] = NW'(1) << $urandom_range(0, NW - 1);
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 7) == 0) for (int i = 0; i < NW; i++) tbl[i] = $urandom;
      run_txn(pend, pw, int'($urandom_range(0, 3)), g);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
